// File: rtl/interrupt_controller_if.sv
// CPU-side interrupt handshake between interrupt_controller and an 8080-style core.
// int_req is the valid: once high, int_opcode is stable until int_ack (the ready) is sampled high
// or the request is withdrawn because cpu_inte dropped. int_ack outside a request has no effect.
interface interrupt_controller_if #(
  parameter int XLEN = 8
);
  logic            cpu_inte;
  logic            int_ack;
  logic            int_req;
  logic [XLEN-1:0] int_opcode;

  modport master (
    input  cpu_inte,
    input  int_ack,
    output int_req,
    output int_opcode
  );

  modport slave (
    output cpu_inte,
    output int_ack,
    input  int_req,
    input  int_opcode
  );
endinterface

// File: rtl/interrupt_controller.sv
// Turns mid_screen/vblank strobe rises into pending RST requests for the CPU,
// with vblank priority and a saturating count of requests lost to overrun.
module interrupt_controller #(
  parameter int XLEN          = 8,
  parameter int MID_VECTOR    = 1,
  parameter int VBLANK_VECTOR = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mid_screen,
  input  logic                  vblank,
  interrupt_controller_if.master cpu,
  output logic [1:0]            pending,
  output logic [7:0]            missed_count,
  output logic                  dbg_state
);

  localparam logic [XLEN-1:0] MID_OPCODE = XLEN'(8'hC7 | (8'(MID_VECTOR) << 3));
  localparam logic [XLEN-1:0] VB_OPCODE  = XLEN'(8'hC7 | (8'(VBLANK_VECTOR) << 3));

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ASSERT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            sel_vb_q, sel_vb_d;
  logic            req_d;
  logic [XLEN-1:0] opcode_d;
  logic            clr_mid, clr_vb;

  logic            mid_prev, vb_prev;
  logic            rise_mid, rise_vb;
  logic            miss_mid, miss_vb;
  logic [1:0]      pending_d;
  logic [8:0]      miss_sum;
  logic [7:0]      missed_d;

  assign dbg_state = (state_q == S_ASSERT);

  // Prev registers come out of reset high so a strobe already high is not a rise.
  assign rise_mid = mid_screen & ~mid_prev;
  assign rise_vb  = vblank & ~vb_prev;

  always_comb begin
    state_d  = state_q;
    sel_vb_d = sel_vb_q;
    req_d    = cpu.int_req;
    opcode_d = cpu.int_opcode;
    clr_mid  = 1'b0;
    clr_vb   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu.cpu_inte && (pending != 2'b00)) begin
          sel_vb_d = pending[1];
          opcode_d = pending[1] ? VB_OPCODE : MID_OPCODE;
          req_d    = 1'b1;
          state_d  = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (cpu.int_ack) begin
          clr_vb   = sel_vb_q;
          clr_mid  = ~sel_vb_q;
          req_d    = 1'b0;
          opcode_d = '0;
          state_d  = S_IDLE;
        end else if (!cpu.cpu_inte) begin
          req_d    = 1'b0;
          opcode_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        req_d    = 1'b0;
        opcode_d = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  // A rise coinciding with the ack of its own source re-arms the bit and is not a miss.
  always_comb begin
    pending_d[0] = rise_mid | (pending[0] & ~clr_mid);
    pending_d[1] = rise_vb | (pending[1] & ~clr_vb);
    miss_mid     = rise_mid & pending[0] & ~clr_mid;
    miss_vb      = rise_vb & pending[1] & ~clr_vb;
    miss_sum     = {1'b0, missed_count} + 9'(miss_mid) + 9'(miss_vb);
    missed_d     = miss_sum[8] ? 8'hFF : miss_sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      sel_vb_q       <= 1'b0;
      cpu.int_req    <= 1'b0;
      cpu.int_opcode <= '0;
      mid_prev       <= 1'b1;
      vb_prev        <= 1'b1;
      pending        <= 2'b00;
      missed_count   <= 8'd0;
    end else begin
      state_q        <= state_d;
      sel_vb_q       <= sel_vb_d;
      cpu.int_req    <= req_d;
      cpu.int_opcode <= opcode_d;
      mid_prev       <= mid_screen;
      vb_prev        <= vblank;
      pending        <= pending_d;
      missed_count   <= missed_d;
    end
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Converts the video timing strobes `mid_screen` and `vblank` into 8080-style interrupt requests for the CPU core. It sits directly downstream of `video_unit` and upstream of the CPU's INT/INTA interface. It latches each strobe's rising edge as a pending request and presents the matching `RST n` opcode to the CPU. It also counts requests that were lost because the previous one of the same source was still pending.

## Interface

Parameters:
- `XLEN`, 8, data width of the opcode bus.
- `MID_VECTOR`, 1, RST number for the mid-screen interrupt (opcode `8'hC7 | MID_VECTOR<<3` = `8'hCF`).
- `VBLANK_VECTOR`, 2, RST number for the vblank interrupt (opcode `8'hD7`).

Ports:
- `clk`  in  1  system clock, same domain as `video_unit`.
- `rst`  in  1  asynchronous, active-high reset.
- `mid_screen`  in  1  level strobe from `video_unit`, high for one full scanline.
- `vblank`  in  1  level strobe from `video_unit`, high for one full scanline.
- `cpu_inte`  in  1  CPU interrupt-enable flag (EI/DI state).
- `int_ack`  in  1  one-cycle pulse: the CPU has taken the opcode on `int_opcode`.
- `int_req`  out  1  interrupt request to the CPU.
- `int_opcode`  out  XLEN  RST opcode for the request being presented.
- `pending`  out  2  bit0 = mid-screen pending, bit1 = vblank pending.
- `missed_count`  out  8  saturating count of dropped requests.

## Operation

- Edge detect: registers `mid_prev` and `vb_prev` hold the previous samples. A rise is `in & ~prev`.
  - Both prev registers reset to 1, so an input already high at reset release is not a rise.
- Pending set/clear:
  - A rise sets its `pending` bit.
  - If a rise arrives while that bit is already 1, the bit stays 1 and `missed_count` increments. The counter saturates at 255.
- FSM, two states:
  - **IDLE**: `int_req`=0, `int_opcode`=0.
    - If `cpu_inte`=1 and `pending` is nonzero: select a source (vblank wins if both are pending), latch its opcode, go to **ASSERT**.
  - **ASSERT**: `int_req`=1, `int_opcode` holds the latched opcode and is stable throughout.
    - `int_ack`=1: clear the selected source's pending bit, go to IDLE.
    - else `cpu_inte`=0: withdraw the request. Go to IDLE, `pending` unchanged.
    - `int_ack` has priority over `cpu_inte`=0 in the same cycle.
- `int_ack` while in IDLE is ignored and has no side effects.
- Simultaneous rise and ack on the same source: the set wins, so the bit stays 1 and a new request follows. This is not counted as a miss.
- Simultaneous rises on both sources: both bits are set, vblank is served first.
- Reset values, asynchronous and applied immediately:
  - FSM in IDLE, `int_req`=0, `int_opcode`=0.
  - `pending`=2'b00, `missed_count`=0.
  - `mid_prev`=1, `vb_prev`=1, selected-source register = mid.
- Reset mid-request drops `int_req` and all pending state without waiting for a clock.

## Timing

- An input rise sampled at edge N sets `pending` from edge N.
- IDLE→ASSERT happens at edge N+1, so `int_req` is high 2 edges after the strobe is first sampled. This requires `cpu_inte`=1 at edge N+1.
- `int_ack` sampled at edge M: `int_req` is low and the pending bit is cleared from edge M.
- At least one IDLE cycle separates consecutive requests. The earliest next `int_req` is from edge M+1.
- All outputs are registered, with no combinational path from any input to any output.
- Strobes are at least one line (800 clk) long. No glitch filtering is required.

## Test plan

- **Basic vblank**: reset, `cpu_inte`=1, raise `vblank` for 800 cycles, ack 5 cycles after `int_req` rises.
  - Required: `int_req`=1 two edges after the rise, `int_opcode`=8'hD7, `pending`=2'b10 until the ack.
  - After the ack: `int_req`=0, `pending`=0, `missed_count`=0.
- **Priority and ordering**: raise `mid_screen` and `vblank` in the same cycle.
  - Required: first request shows opcode D7; after its ack, one IDLE cycle, then the second request shows CF.
  - Required: `pending` goes 11 → 01 → 00.
- **Interrupts disabled**: `cpu_inte`=0 while `mid_screen` pulses.
  - Required: `pending`=01 and `int_req` stays 0.
  - Set `cpu_inte`=1: `int_req` rises one edge later with CF.
- **Withdraw**: drop `cpu_inte` while in ASSERT.
  - Required: `int_req`=0 next edge, `pending` unchanged.
  - Re-enable `cpu_inte`: the request is re-presented.
- **Overrun and saturation**: never ack and pulse `vblank` 300 times.
  - Required: `missed_count`=255 (saturated), `pending[1]`=1.
  - Ack in the same cycle as a new vblank rise: `pending[1]` stays 1 and the count is unchanged.
- **Reset behaviour**:
  - Release reset with `vblank` held high: no request is made.
  - Assert `rst` mid-ASSERT: `int_req` goes to 0 asynchronously and `pending`=0.
  - Spurious `int_ack` in IDLE: no state change.
